// File: rtl/idelay_array_ctrl.sv
// ---------------------------------------------------------------------------
// idelay_array_ctrl
//   Multi-lane programmable input delay. Each lane carries its own buffer
//   delay chain, a tap mux, a tap counter, a pipeline load register and a
//   small IDLE/SETTLE FSM. The FSM keeps tap changes from arriving faster
//   than the chain can settle. The block sits between the pad buffers and
//   the RGMII/IDDR capture logic.
//
// Ports
//   i_c            in   1                clock, rising edge
//   i_regrst_n     in   1                synchronous active-low reset
//   i_datain       in   NUM_CH           per-lane data into the delay chain
//   i_ce           in   NUM_CH           per-lane step enable
//   i_inc          in   NUM_CH           per-lane direction, 1 = increment
//   i_ld           in   NUM_CH           per-lane load strobe
//   i_ldpipeen     in   NUM_CH           per-lane pipeline register capture
//   i_cntvaluein   in   NUM_CH*TAP_BITS  load values, lane k at [k*TAP_BITS +: TAP_BITS]
//   o_dataout      out  NUM_CH           delayed data (combinational path)
//   o_cntvalueout  out  NUM_CH*TAP_BITS  current tap per lane, same packing
//   o_rdy          out  NUM_CH           1 = lane accepts LD/CE this cycle
// ---------------------------------------------------------------------------

// One delay element of the chain. In the ASAP7 flow this wrapper is bound to
// BUFx2_ASAP7_75t_R and kept from being optimised away by the physical
// constraints; in RTL simulation it is a zero-delay wire.
module idelay_array_ctrl_buf (
  input  logic i_a,
  output logic o_y
);
  assign o_y = i_a;
endmodule

module idelay_array_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int TAP_BITS       = 5,
  parameter int STAGES_PER_TAP = 2,
  parameter int INIT_VALUE     = 0,
  parameter int FIXED_MODE     = 0,
  parameter int WRAP_MODE      = 1,
  parameter int PIPE_SEL       = 0,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                         i_c,
  input  logic                         i_regrst_n,
  input  logic [NUM_CH-1:0]            i_datain,
  input  logic [NUM_CH-1:0]            i_ce,
  input  logic [NUM_CH-1:0]            i_inc,
  input  logic [NUM_CH-1:0]            i_ld,
  input  logic [NUM_CH-1:0]            i_ldpipeen,
  input  logic [NUM_CH*TAP_BITS-1:0]   i_cntvaluein,
  output logic [NUM_CH-1:0]            o_dataout,
  output logic [NUM_CH*TAP_BITS-1:0]   o_cntvalueout,
  output logic [NUM_CH-1:0]            o_rdy
);

  localparam int NUM_TAPS = 2 ** TAP_BITS;
  // Settle counter only has to hold SETTLE_CYCLES-1.
  localparam int CNT_W    = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TAP_BITS-1:0] TAP_MAX  = {TAP_BITS{1'b1}};
  localparam logic [TAP_BITS-1:0] TAP_MIN  = {TAP_BITS{1'b0}};
  localparam logic [TAP_BITS-1:0] TAP_ONE  = TAP_BITS'(1);
  localparam logic [TAP_BITS-1:0] TAP_INIT = TAP_BITS'(INIT_VALUE);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } lane_state_e;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane

    logic [TAP_BITS-1:0] w_tap;
    logic                w_rdy;
    logic [TAP_BITS-1:0] r_pipe;
    logic [TAP_BITS-1:0] w_cntin;
    logic [NUM_TAPS-1:0] w_chain;
    logic                w_sel;
    logic                w_unused_pipe;

    assign w_cntin = i_cntvaluein[k*TAP_BITS +: TAP_BITS];

    // Pipeline load register: captures regardless of the lane FSM state.
    always_ff @(posedge i_c) begin
      if (!i_regrst_n) begin
        r_pipe <= TAP_MIN;
      end else if (i_ldpipeen[k]) begin
        r_pipe <= w_cntin;
      end else begin
        r_pipe <= r_pipe;
      end
    end

    // The pipe register is architecturally visible only with PIPE_SEL=1.
    assign w_unused_pipe = ^r_pipe;

    if (FIXED_MODE != 0) begin : g_fixed
      logic w_unused_cmd;
      assign w_tap        = TAP_INIT;
      assign w_rdy        = 1'b1;
      assign w_unused_cmd = ^{i_ce[k], i_inc[k], i_ld[k]};
    end else begin : g_ctrl
      lane_state_e         r_state;
      lane_state_e         w_state_nxt;
      logic [CNT_W-1:0]    r_cnt;
      logic [CNT_W-1:0]    w_cnt_nxt;
      logic [TAP_BITS-1:0] r_tap;
      logic [TAP_BITS-1:0] w_tap_nxt;
      logic [TAP_BITS-1:0] w_load_val;
      logic [TAP_BITS-1:0] w_step_val;
      logic                w_cmd;

      // With PIPE_SEL=1 a same-edge LDPIPEEN still sees the old r_pipe here.
      assign w_load_val = (PIPE_SEL != 0) ? r_pipe : w_cntin;

      // One-step tap arithmetic with wrap or saturate at the ends.
      always_comb begin
        w_step_val = r_tap;
        if (i_inc[k]) begin
          if (r_tap == TAP_MAX) begin
            w_step_val = (WRAP_MODE != 0) ? TAP_MIN : TAP_MAX;
          end else begin
            w_step_val = r_tap + TAP_ONE;
          end
        end else begin
          if (r_tap == TAP_MIN) begin
            w_step_val = (WRAP_MODE != 0) ? TAP_MAX : TAP_MIN;
          end else begin
            w_step_val = r_tap - TAP_ONE;
          end
        end
      end

      // Lane state, settle counter and tap registers.
      always_ff @(posedge i_c) begin
        if (!i_regrst_n) begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
          r_tap   <= TAP_INIT;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_tap   <= w_tap_nxt;
        end
      end

      // Lane FSM next-state: commands only accepted in IDLE, dropped in SETTLE.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tap_nxt   = r_tap;
        w_cmd       = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (i_ld[k]) begin
              w_tap_nxt = w_load_val;
              w_cmd     = 1'b1;
            end else if (i_ce[k]) begin
              w_tap_nxt = w_step_val;
              w_cmd     = 1'b1;
            end else begin
              w_cmd     = 1'b0;
            end
            // Any command enters SETTLE, even if the tap value is unchanged.
            if (w_cmd && (SETTLE_CYCLES != 0)) begin
              w_state_nxt = ST_SETTLE;
              w_cnt_nxt   = SETTLE_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == CNT_ZERO) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt   = r_cnt - CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        endcase
      end

      assign w_tap = r_tap;
      assign w_rdy = (r_state == ST_IDLE);
    end

    // Delay chain: tap 0 is one buffer, every further tap adds
    // STAGES_PER_TAP buffers. Each stage is its own scalar so the chain
    // never feeds back into a single vector.
    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
      logic w_tap_out;
      if (t == 0) begin : g_head
        idelay_array_ctrl_buf u_buf (.i_a(i_datain[k]), .o_y(w_tap_out));
      end else begin : g_body
        for (genvar s = 0; s < STAGES_PER_TAP; s++) begin : g_stg
          logic w_o;
          if (s == 0) begin : g_in
            idelay_array_ctrl_buf u_buf (.i_a(g_tap[t-1].w_tap_out), .o_y(w_o));
          end else begin : g_mid
            idelay_array_ctrl_buf u_buf (.i_a(g_stg[s-1].w_o), .o_y(w_o));
          end
        end
        assign w_tap_out = g_stg[STAGES_PER_TAP-1].w_o;
      end
      assign w_chain[t] = w_tap_out;
    end

    assign w_sel = w_chain[w_tap];

    idelay_array_ctrl_buf u_obuf (.i_a(w_sel), .o_y(o_dataout[k]));

    assign o_cntvalueout[k*TAP_BITS +: TAP_BITS] = w_tap;
    assign o_rdy[k]                              = w_rdy;
  end

endmodule

// File: tb/tb_idelay_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_idelay_array_ctrl
//   Directed bench for idelay_array_ctrl. Three instances share the stimulus:
//     u_dut_w : INIT 3, wrap, pipe-select load, 4-cycle settle
//     u_dut_s : INIT 3, saturate, direct load, no settle
//     u_dut_f : INIT 3, fixed taps
//   Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_idelay_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  datain, ce, inc, ld, ldpe;
  logic [19:0] cntin;

  logic [3:0]  dout_w, dout_s, dout_f;
  logic [19:0] cnt_w, cnt_s, cnt_f;
  logic [3:0]  rdy_w, rdy_s, rdy_f;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idelay_array_ctrl #(.NUM_CH(4), .TAP_BITS(5), .STAGES_PER_TAP(2), .INIT_VALUE(3),
    .FIXED_MODE(0), .WRAP_MODE(1), .PIPE_SEL(1), .SETTLE_CYCLES(4)) u_dut_w (
    .i_c(clk), .i_regrst_n(rst_n), .i_datain(datain), .i_ce(ce), .i_inc(inc),
    .i_ld(ld), .i_ldpipeen(ldpe), .i_cntvaluein(cntin),
    .o_dataout(dout_w), .o_cntvalueout(cnt_w), .o_rdy(rdy_w));

  idelay_array_ctrl #(.NUM_CH(4), .TAP_BITS(5), .STAGES_PER_TAP(2), .INIT_VALUE(3),
    .FIXED_MODE(0), .WRAP_MODE(0), .PIPE_SEL(0), .SETTLE_CYCLES(0)) u_dut_s (
    .i_c(clk), .i_regrst_n(rst_n), .i_datain(datain), .i_ce(ce), .i_inc(inc),
    .i_ld(ld), .i_ldpipeen(ldpe), .i_cntvaluein(cntin),
    .o_dataout(dout_s), .o_cntvalueout(cnt_s), .o_rdy(rdy_s));

  idelay_array_ctrl #(.NUM_CH(4), .TAP_BITS(5), .STAGES_PER_TAP(2), .INIT_VALUE(3),
    .FIXED_MODE(1), .WRAP_MODE(1), .PIPE_SEL(0), .SETTLE_CYCLES(4)) u_dut_f (
    .i_c(clk), .i_regrst_n(rst_n), .i_datain(datain), .i_ce(ce), .i_inc(inc),
    .i_ld(ld), .i_ldpipeen(ldpe), .i_cntvaluein(cntin),
    .o_dataout(dout_f), .o_cntvalueout(cnt_f), .o_rdy(rdy_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [19:0] v, input int k);
    return {27'd0, v[k*5 +: 5]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce   = 4'b0000;
    ld   = 4'b0000;
    ldpe = 4'b0000;
    repeat (n) tick();
  endtask

  task automatic setin(input int k, input logic [4:0] v);
    cntin[k*5 +: 5] = v;
  endtask

  initial begin
    // T1: reset with every command asserted; all of them must be ignored.
    rst_n  = 1'b0;
    datain = 4'b1010;
    ce     = 4'b1111;
    inc    = 4'b1111;
    ld     = 4'b1111;
    ldpe   = 4'b1111;
    cntin  = {4{5'd9}};
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tap_w%0d", k), lane(cnt_w, k), 32'd3);
      chk($sformatf("rst_tap_s%0d", k), lane(cnt_s, k), 32'd3);
      chk($sformatf("rst_tap_f%0d", k), lane(cnt_f, k), 32'd3);
    end
    chk("rst_rdy_w", {28'd0, rdy_w}, 32'd15);
    chk("rst_rdy_s", {28'd0, rdy_s}, 32'd15);
    chk("rst_rdy_f", {28'd0, rdy_f}, 32'd15);
    chk("rst_dout_w", {28'd0, dout_w}, 32'd10);

    rst_n = 1'b1;
    inc   = 4'b0000;
    idle(1);
    chk("post_rst_rdy_w", {28'd0, rdy_w}, 32'd15);
    chk("post_rst_tap1_w", lane(cnt_w, 1), 32'd3);

    // T2: lane0 to 31 then wrap / saturate up, then 0 and down.
    setin(0, 5'd31);
    ldpe = 4'b0001;
    tick();
    ldpe = 4'b0000;
    ld   = 4'b0001;
    tick();
    chk("ld31_w", lane(cnt_w, 0), 32'd31);
    chk("ld31_s", lane(cnt_s, 0), 32'd31);
    chk("ld31_rdy_w", {28'd0, rdy_w}, 32'd14);
    chk("ld31_rdy_s", {28'd0, rdy_s}, 32'd15);
    idle(3);
    chk("settle_last_rdy_w", {28'd0, rdy_w}, 32'd14);
    idle(1);
    chk("settle_done_rdy_w", {28'd0, rdy_w}, 32'd15);

    ce  = 4'b0001;
    inc = 4'b0001;
    tick();
    chk("inc_wrap_w", lane(cnt_w, 0), 32'd0);
    chk("inc_sat_s", lane(cnt_s, 0), 32'd31);
    chk("fixed_tap_f", lane(cnt_f, 0), 32'd3);
    chk("fixed_rdy_f", {28'd0, rdy_f}, 32'd15);
    idle(4);

    setin(0, 5'd0);
    ldpe = 4'b0001;
    tick();
    ldpe = 4'b0000;
    ld   = 4'b0001;
    tick();
    chk("ld0_w", lane(cnt_w, 0), 32'd0);
    chk("ld0_s", lane(cnt_s, 0), 32'd0);
    idle(4);

    ce  = 4'b0001;
    inc = 4'b0000;
    tick();
    chk("dec_wrap_w", lane(cnt_w, 0), 32'd31);
    chk("dec_sat_s", lane(cnt_s, 0), 32'd0);
    idle(4);
    datain = 4'b0101;
    #1;
    chk("dout_w_a", {28'd0, dout_w}, 32'd5);
    chk("dout_s_a", {28'd0, dout_s}, 32'd5);

    // T3: settle on lane1; second CE during the window is dropped.
    ce  = 4'b0010;
    inc = 4'b0010;
    tick();
    chk("t3_tap1_w_a", lane(cnt_w, 1), 32'd4);
    chk("t3_rdy_w_a", {28'd0, rdy_w}, 32'd13);
    chk("t3_tap1_s_a", lane(cnt_s, 1), 32'd4);
    tick();
    chk("t3_tap1_w_drop", lane(cnt_w, 1), 32'd4);
    chk("t3_rdy_w_b", {28'd0, rdy_w}, 32'd13);
    chk("t3_tap1_s_b", lane(cnt_s, 1), 32'd5);
    idle(1);
    chk("t3_rdy_w_c", {28'd0, rdy_w}, 32'd13);
    idle(1);
    chk("t3_rdy_w_d", {28'd0, rdy_w}, 32'd13);
    idle(1);
    chk("t3_rdy_w_e", {28'd0, rdy_w}, 32'd15);
    chk("t3_tap1_w_end", lane(cnt_w, 1), 32'd4);

    // T4: pipe load on lane2. Pipe was cleared by reset (LDPIPEEN ignored then).
    ld = 4'b0100;
    tick();
    chk("t4_pipe_rst_w", lane(cnt_w, 2), 32'd0);
    chk("t4_direct_s", lane(cnt_s, 2), 32'd9);
    idle(4);
    ldpe = 4'b0100;
    tick();
    ldpe = 4'b0000;
    ld   = 4'b0100;
    tick();
    chk("t4_pipe9_w", lane(cnt_w, 2), 32'd9);
    idle(4);
    setin(2, 5'd17);
    ld   = 4'b0100;
    ldpe = 4'b0100;
    tick();
    chk("t4_old_pipe_w", lane(cnt_w, 2), 32'd9);
    chk("t4_direct17_s", lane(cnt_s, 2), 32'd17);
    idle(4);
    ld = 4'b0100;
    tick();
    chk("t4_new_pipe_w", lane(cnt_w, 2), 32'd17);
    idle(4);

    // T5: reset in the middle of a settle window.
    setin(3, 5'd20);
    ldpe = 4'b1000;
    tick();
    ldpe = 4'b0000;
    ld   = 4'b1000;
    tick();
    chk("t5_ld20_w", lane(cnt_w, 3), 32'd20);
    chk("t5_busy_w", {28'd0, rdy_w}, 32'd7);
    rst_n = 1'b0;
    ce    = 4'b1111;
    ld    = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_rst_tap_w%0d", k), lane(cnt_w, k), 32'd3);
      chk($sformatf("t5_rst_tap_s%0d", k), lane(cnt_s, k), 32'd3);
    end
    chk("t5_rst_rdy_w", {28'd0, rdy_w}, 32'd15);
    rst_n = 1'b1;
    idle(1);
    chk("t5_no_resid_rdy_w", {28'd0, rdy_w}, 32'd15);
    chk("t5_tap3_w", lane(cnt_w, 3), 32'd3);

    // T6: LD beats CE on the same lane.
    setin(1, 5'd12);
    ldpe = 4'b0010;
    tick();
    ldpe = 4'b0000;
    ld   = 4'b0010;
    ce   = 4'b0010;
    inc  = 4'b0010;
    tick();
    chk("t6_prio_w", lane(cnt_w, 1), 32'd12);
    chk("t6_prio_s", lane(cnt_s, 1), 32'd12);
    chk("t6_rdy_w", {28'd0, rdy_w}, 32'd13);
    idle(4);
    datain = 4'b1111;
    #1;
    chk("dout_w_b", {28'd0, dout_w}, 32'd15);
    chk("dout_f_b", {28'd0, dout_f}, 32'd15);
    chk("end_tap_f", lane(cnt_f, 2), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
